// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared definitions for the common-data-bus path of the out-of-order core:
// default tag/data widths, source identifiers used on cdb_src, and the
// (tag, value) packet that the register alias table and reservation stations
// also take on their bus inputs.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;

  // Source identifiers; they also equal the expected tag MSB of each class.
  localparam logic SRC_ADD = 1'b0;
  localparam logic SRC_MUL = 1'b1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the two functional-unit result handshakes and the CDB broadcast.
//   master : the functional units / broadcast consumers (drive *_res_valid,
//            *_res_tag, *_res_value; observe ready, cdb_* and tag_err)
//   slave  : the arbiter (observes results, drives ready, cdb_* and tag_err)
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W
);

  logic              add_res_valid;
  logic [TAG_W-1:0]  add_res_tag;
  logic [DATA_W-1:0] add_res_value;
  logic              add_res_ready;

  logic              mul_res_valid;
  logic [TAG_W-1:0]  mul_res_tag;
  logic [DATA_W-1:0] mul_res_value;
  logic              mul_res_ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_src;
  logic              tag_err;

  modport master (
    output add_res_valid, add_res_tag, add_res_value,
    output mul_res_valid, mul_res_tag, mul_res_value,
    input  add_res_ready, mul_res_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_src, tag_err
  );

  modport slave (
    input  add_res_valid, add_res_tag, add_res_value,
    input  mul_res_valid, mul_res_tag, mul_res_value,
    output add_res_ready, mul_res_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_src, tag_err
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO holding completed results of one functional unit.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_pkt  write request and packet (ignored while full)
//   pop             read request (ignored while empty)
//   head_pkt        packet at the read pointer
//   full, empty     status derived from the registered count only
// -----------------------------------------------------------------------------
module result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type pkt_t = cdb_pkt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  pkt_t push_pkt,
  input  logic pop,
  output pkt_t head_pkt,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pkt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_pkt = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_pkt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Buffers adder and multiplier results in per-source FIFOs and broadcasts one
// result per cycle on the common data bus, round-robin when both are pending.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         cdb_arbiter_if.slave: result handshakes in, ready out,
//               registered CDB broadcast (valid/tag/value/src) and the sticky
//               tag-class error flag out
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
  parameter int DATA_W = cdb_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  cdb_arbiter_if.slave      bus
);

  import cdb_arbiter_pkg::*;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } pkt_t;

  pkt_t add_in, mul_in, add_head, mul_head;
  logic add_full, add_empty, mul_full, mul_empty;
  logic add_push, mul_push;
  logic grant_add, grant_mul;

  logic cdb_valid_q, cdb_valid_d;
  pkt_t cdb_pkt_q,   cdb_pkt_d;
  logic cdb_src_q,   cdb_src_d;
  logic last_grant_q, last_grant_d;
  logic tag_err_q,   tag_err_d;

  // Ready comes from registered FIFO state only: a full FIFO stays not-ready
  // even when it is being drained this cycle.
  assign bus.add_res_ready = !add_full;
  assign bus.mul_res_ready = !mul_full;
  assign add_push = bus.add_res_valid && !add_full;
  assign mul_push = bus.mul_res_valid && !mul_full;
  assign add_in   = '{tag: bus.add_res_tag, value: bus.add_res_value};
  assign mul_in   = '{tag: bus.mul_res_tag, value: bus.mul_res_value};

  result_fifo #(.DEPTH(DEPTH), .pkt_t(pkt_t)) u_add_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (add_push),
    .push_pkt (add_in),
    .pop      (grant_add),
    .head_pkt (add_head),
    .full     (add_full),
    .empty    (add_empty)
  );

  result_fifo #(.DEPTH(DEPTH), .pkt_t(pkt_t)) u_mul_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (mul_push),
    .push_pkt (mul_in),
    .pop      (grant_mul),
    .head_pkt (mul_head),
    .full     (mul_full),
    .empty    (mul_empty)
  );

  // Round-robin on pre-edge FIFO state; a contested grant goes to the source
  // that did not win last time.
  always_comb begin
    grant_add = 1'b0;
    grant_mul = 1'b0;
    if (!add_empty && !mul_empty) begin
      if (last_grant_q == SRC_MUL) grant_add = 1'b1;
      else                         grant_mul = 1'b1;
    end else if (!add_empty) begin
      grant_add = 1'b1;
    end else if (!mul_empty) begin
      grant_mul = 1'b1;
    end
  end

  // Broadcast register: valid pulses for one cycle, payload holds otherwise.
  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_pkt_d    = cdb_pkt_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (grant_add) begin
      cdb_valid_d  = 1'b1;
      cdb_pkt_d    = add_head;
      cdb_src_d    = SRC_ADD;
      last_grant_d = SRC_ADD;
    end else if (grant_mul) begin
      cdb_valid_d  = 1'b1;
      cdb_pkt_d    = mul_head;
      cdb_src_d    = SRC_MUL;
      last_grant_d = SRC_MUL;
    end
    // Tag MSB must match the station class of the producing unit; sticky.
    tag_err_d = tag_err_q
              | (add_push && (bus.add_res_tag[TAG_W-1] != SRC_ADD))
              | (mul_push && (bus.mul_res_tag[TAG_W-1] != SRC_MUL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q  <= 1'b0;
      cdb_pkt_q    <= '0;
      cdb_src_q    <= SRC_ADD;
      last_grant_q <= SRC_MUL;
      tag_err_q    <= 1'b0;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_pkt_q    <= cdb_pkt_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_pkt_q.tag;
  assign bus.cdb_value = cdb_pkt_q.value;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.tag_err   = tag_err_q;

endmodule
